// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot loader: loader state encoding, frame
// geometry and the image-length acceptance rule.
//
// Frame byte order on the Rx stream:
//   LEN_LO, LEN_HI          16-bit word count N, little-endian
//   4*N payload bytes       each word little-endian (byte 0 -> bits 7:0)
//   CHK                     XOR of every preceding frame byte
package instr_loader_pkg;

  localparam int DEF_DEPTH_WORDS = 64;
  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 32;

  typedef enum logic [2:0] {
    LD_LEN_LO  = 3'd0,
    LD_LEN_HI  = 3'd1,
    LD_PAYLOAD = 3'd2,
    LD_CHK     = 3'd3,
    LD_DONE    = 3'd4,
    LD_ERROR   = 3'd5
  } ld_state_t;

  // An image is loadable when it has at least one word and fits the memory.
  function automatic logic len_ok(input logic [15:0] n, input int unsigned depth);
    return (n != 16'd0) && ({16'd0, n} <= depth);
  endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Packs accepted payload bytes into a 32-bit little-endian word and pulses
// word_ready for one cycle once the fourth byte of a word is in place.
module word_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              load,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic              last_byte
);

  logic [1:0] b;

  // The next load completes the current word.
  assign last_byte = (b == 2'd3);

  // Insert each byte into its lane; the full word and its pulse appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b          <= 2'd0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= load && last_byte;
      if (load) begin
        word[{b, 3'b000} +: BYTE_W] <= byte_in;
        b                           <= b + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked byte frame, writes the
// packed words into instruction memory and releases the core reset only after
// the whole image and its checksum have been accepted.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [WORD_W-1:0] WD,
  output logic              CoreRST,
  output logic              Done,
  output logic              Error
);

  ld_state_t         state;
  ld_state_t         nxt;
  logic              accept;
  logic              pk_load;
  logic              pk_last;
  logic              rx_ready_nxt;
  logic [BYTE_W-1:0] len_lo;
  logic [15:0]       len_word;
  logic [ADDR_W-1:0] nlast;
  logic [BYTE_W-1:0] csum;

  assign accept   = RxValid && RxReady;
  assign pk_load  = accept && (state == LD_PAYLOAD);
  assign len_word = {RxData, len_lo};

  word_packer u_packer (
    .clk        (CLK),
    .rst        (RST),
    .byte_in    (RxData),
    .load       (pk_load),
    .word       (WD),
    .word_ready (WE),
    .last_byte  (pk_last)
  );

  // Frame parsing: advance only on accepted bytes, DONE/ERROR are terminal.
  always_comb begin
    nxt          = state;
    rx_ready_nxt = 1'b0;
    case (state)
      LD_LEN_LO:  if (accept) nxt = LD_LEN_HI;
      LD_LEN_HI:  if (accept) nxt = len_ok(len_word, DEPTH_WORDS) ? LD_PAYLOAD : LD_ERROR;
      // WA still holds the index of the word being completed here.
      LD_PAYLOAD: if (pk_load && pk_last && (WA == nlast)) nxt = LD_CHK;
      LD_CHK:     if (accept) nxt = (RxData == csum) ? LD_DONE : LD_ERROR;
      LD_DONE:    nxt = LD_DONE;
      LD_ERROR:   nxt = LD_ERROR;
      default:    nxt = LD_ERROR;
    endcase
    rx_ready_nxt = (nxt != LD_DONE) && (nxt != LD_ERROR);
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= LD_LEN_LO;
      RxReady <= 1'b0;
      CoreRST <= 1'b1;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      state   <= nxt;
      RxReady <= rx_ready_nxt;
      CoreRST <= (state != LD_DONE);
      Done    <= (state == LD_DONE);
      Error   <= (state == LD_ERROR);
    end
  end

  // Length capture, running checksum and write address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_lo <= '0;
      nlast  <= '0;
      csum   <= '0;
      WA     <= '0;
    end else begin
      if (accept && (state == LD_LEN_LO)) len_lo <= RxData;
      if (accept && (state == LD_LEN_HI)) nlast  <= ADDR_W'(len_word - 16'd1);
      if (accept && ((state == LD_LEN_LO) || (state == LD_LEN_HI) || (state == LD_PAYLOAD)))
        csum <= csum ^ RxData;
      // Stop at the last word so WA never points past the image.
      if (WE && (WA != nlast)) WA <= WA + ADDR_W'(1);
    end
  end

endmodule
